// File: rtl/risc8_pkg.sv
// risc8_pkg: shared arbiter state, read-owner and read-tag types for the risc8 memory path
package risc8_pkg;
  typedef enum logic {ARB_DPRI, ARB_FFORCE} arb_state_e;
  typedef enum logic {OWN_IF, OWN_D} rd_owner_e;
  typedef struct packed {
    logic      v;
    rd_owner_e o;
  } rd_tag_t;
  localparam rd_tag_t TAG_NONE = '{v: 1'b0, o: OWN_IF};
endpackage

// File: rtl/risc8_rd_tag_pipe.sv
// risc8_rd_tag_pipe: RD_LAT-deep shift of read tags so each response finds its owner
module risc8_rd_tag_pipe
  import risc8_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag,
  output logic    o_d_busy
);
  rd_tag_t r_pipe [RD_LAT];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= TAG_NONE;
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end
  assign o_tag = r_pipe[RD_LAT-1];
  // the exit stage still counts: d_rvalid has not been consumed until it pulses
  always_comb begin
    o_d_busy = 1'b0;
    for (int i = 0; i < RD_LAT; i++) o_d_busy = o_d_busy | (r_pipe[i].v && r_pipe[i].o == OWN_D);
  end
endmodule

// File: rtl/risc8_mem_arbiter.sv
// risc8_mem_arbiter: shares one RAM port between fetch and load/store with anti-starvation
module risc8_mem_arbiter
  import risc8_pkg::*;
#(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int RD_LAT    = 1,
  parameter int MAX_DSTRK = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_gnt,
  output logic          o_if_rvalid,
  output logic [DW-1:0] o_if_rdata,
  input  logic          i_d_req,
  input  logic          i_d_we,
  input  logic [AW-1:0] i_d_addr,
  input  logic [DW-1:0] i_d_wdata,
  output logic          o_d_gnt,
  output logic          o_d_rvalid,
  output logic [DW-1:0] o_d_rdata,
  output logic          o_stall,
  output logic [AW-1:0] o_ram_addr,
  output logic          o_ram_wr_en,
  output logic          o_ram_rd_en,
  output logic [DW-1:0] o_ram_wr_data,
  input  logic [DW-1:0] i_ram_rd_data
);
  arb_state_e    r_state, w_state_nxt;
  logic [3:0]    r_streak, w_streak_nxt;
  logic          w_if_gnt, w_d_gnt, w_rd;
  rd_tag_t       w_tag_in, w_tag_out;
  logic          w_d_busy;
  logic [DW-1:0] r_if_rdata, r_d_rdata;
  always_comb begin
    w_if_gnt     = 1'b0;
    w_d_gnt      = 1'b0;
    w_state_nxt  = ARB_DPRI;
    w_streak_nxt = '0;
    if (rst_n) begin
      if (r_state == ARB_FFORCE) begin
        w_if_gnt = i_if_req;
        w_d_gnt  = i_d_req & ~i_if_req;
      end else begin
        w_d_gnt  = i_d_req;
        w_if_gnt = i_if_req & ~i_d_req;
        // only data grants that make a pending fetch wait count toward the streak
        if (i_d_req && i_if_req) begin
          w_streak_nxt = r_streak + 4'd1;
          w_state_nxt  = (w_streak_nxt == 4'(MAX_DSTRK)) ? ARB_FFORCE : ARB_DPRI;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB_DPRI;
      r_streak   <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
      if (o_if_rvalid) r_if_rdata <= i_ram_rd_data;
      if (o_d_rvalid) r_d_rdata <= i_ram_rd_data;
    end
  end
  assign o_if_gnt      = w_if_gnt;
  assign o_d_gnt       = w_d_gnt;
  assign w_rd          = w_if_gnt | (w_d_gnt & ~i_d_we);
  assign o_ram_rd_en   = w_rd;
  assign o_ram_wr_en   = w_d_gnt & i_d_we;
  assign o_ram_addr    = w_if_gnt ? i_if_addr : w_d_gnt ? i_d_addr : '0;
  assign o_ram_wr_data = o_ram_wr_en ? i_d_wdata : '0;
  assign w_tag_in      = '{v: w_rd, o: w_if_gnt ? OWN_IF : OWN_D};
  risc8_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_tag    (w_tag_in),
    .o_tag    (w_tag_out),
    .o_d_busy (w_d_busy)
  );
  assign o_if_rvalid = w_tag_out.v && w_tag_out.o == OWN_IF;
  assign o_d_rvalid  = w_tag_out.v && w_tag_out.o == OWN_D;
  assign o_if_rdata  = o_if_rvalid ? i_ram_rd_data : r_if_rdata;
  assign o_d_rdata   = o_d_rvalid ? i_ram_rd_data : r_d_rdata;
  assign o_stall     = rst_n & ((i_d_req & ~w_d_gnt) | w_d_busy | (i_if_req & ~w_if_gnt));
endmodule
